// File: rtl/pipe_stall_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : pipe_stall_ctrl_pkg                                         |
// | Brief   : Shared stage indices, reset level and controller states.    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package pipe_stall_ctrl_pkg;

    localparam logic [2:0] STAGE_IF  = 3'd0;
    localparam logic [2:0] STAGE_ID  = 3'd1;
    localparam logic [2:0] STAGE_EX  = 3'd2;
    localparam logic [2:0] STAGE_MEM = 3'd3;
    localparam logic [2:0] STAGE_WB  = 3'd4;

    localparam logic RST_ACTIVE = 1'b0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_PEND  = 2'd2
    } ctrl_state_e;

endpackage : pipe_stall_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_stall_ctrl_depth_enc.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : pipe_stall_ctrl_depth_enc                                   |
// | Brief   : Deepest stage frozen by the active stall requesters.        |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module pipe_stall_ctrl_depth_enc
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int                  NREQ      = 4,
    parameter int                  SW        = 3,
    parameter logic [NREQ*SW-1:0]  REQ_STAGE = {3'd3, 3'd0, 3'd3, 3'd0}
) (
    input  logic [NREQ-1:0] i_req,
    output logic            o_valid,
    output logic [SW-1:0]   o_depth
);

    logic [SW-1:0] w_stage [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign w_stage[i] = REQ_STAGE[i*SW +: SW];
    end

    always_comb begin
        o_valid = 1'b0;
        o_depth = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (i_req[i]) begin
                o_valid = 1'b1;
                if (w_stage[i] > o_depth) begin
                    o_depth = w_stage[i];
                end
            end
        end
    end

endmodule : pipe_stall_ctrl_depth_enc
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : pipe_stall_ctrl                                             |
// | Brief   : Pipeline stall/flush controller with deferred flush,        |
// |           stall performance counter and hang watchdog.                |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int                  STAGES    = 5,
    parameter int                  NREQ      = 4,
    parameter int                  SW        = 3,
    parameter logic [NREQ*SW-1:0]  REQ_STAGE = {3'd3, 3'd0, 3'd3, 3'd0},
    parameter int                  CNT_W     = 16,
    parameter int                  TO_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   stall_req,
    input  logic              flush_req,
    input  logic [SW-1:0]     flush_stage,
    input  logic              cnt_clr,
    output logic [STAGES-1:0] stall,
    output logic [STAGES-1:0] bubble,
    output logic [STAGES-1:0] flush,
    output logic [SW-1:0]     halt_code,
    output logic              flush_pend,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic              hang
);

    // One extra bit so a whole-pipe flush (index STAGES) is representable.
    localparam int             FW       = SW + 1;
    localparam logic [FW-1:0]  C_STAGES = FW'(STAGES);
    localparam int             WD_W     = $clog2(TO_CYCLES + 1);
    localparam logic [WD_W-1:0] C_TO    = WD_W'(TO_CYCLES);

    ctrl_state_e       r_state;
    ctrl_state_e       w_state_nxt;
    logic [FW-1:0]     r_pend_stage;
    logic [CNT_W-1:0]  r_cnt;
    logic [WD_W-1:0]   r_wd;
    logic              r_hang;

    logic              w_valid;
    logic [SW-1:0]     w_depth;
    logic [FW-1:0]     w_dep_ext;
    logic [FW-1:0]     w_fstage;
    logic              w_live;
    logic              w_new_blk;
    logic              w_new_iss;
    logic              w_pend_act;
    logic              w_pend_iss;
    logic              w_pend_blk;
    logic              w_any_iss;
    logic              w_pend_nxt;
    logic [FW-1:0]     w_ps_a;
    logic [FW-1:0]     w_ps_b;
    logic [FW-1:0]     w_ps_nxt;
    logic              w_keep_stall;
    logic              w_any_stall;
    logic [STAGES-1:0] w_stall_raw;
    logic [STAGES-1:0] w_bubble_raw;
    logic [STAGES-1:0] w_flush_raw;

    pipe_stall_ctrl_depth_enc #(
        .NREQ      (NREQ),
        .SW        (SW),
        .REQ_STAGE (REQ_STAGE)
    ) u_depth_enc (
        .i_req   (stall_req),
        .o_valid (w_valid),
        .o_depth (w_depth)
    );

    assign w_live     = (rst != RST_ACTIVE);
    assign w_dep_ext  = {1'b0, w_depth};
    assign w_fstage   = ({1'b0, flush_stage} > C_STAGES) ? C_STAGES : {1'b0, flush_stage};

    assign w_new_blk  = flush_req && w_valid && (w_dep_ext >= w_fstage);
    assign w_new_iss  = flush_req && !w_new_blk;
    assign w_pend_act = (r_state == ST_PEND);
    assign w_pend_iss = w_pend_act && !(w_valid && (w_dep_ext >= r_pend_stage));
    assign w_pend_blk = w_pend_act && !w_pend_iss;
    assign w_any_iss  = w_new_iss || w_pend_iss;

    // An issued flush always covers every stalled stage, so it subsumes
    // both the stall and any flush still blocked this cycle.
    assign w_pend_nxt = (w_new_blk || w_pend_blk) && !w_any_iss;
    assign w_ps_a     = w_pend_blk ? r_pend_stage : '0;
    assign w_ps_b     = w_new_blk  ? w_fstage     : '0;
    assign w_ps_nxt   = (w_ps_a > w_ps_b) ? w_ps_a : w_ps_b;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        assign w_stall_raw[s]  = w_valid && (w_dep_ext >= FW'(s));
        assign w_bubble_raw[s] = w_valid && ((w_dep_ext + FW'(1)) == FW'(s));
        assign w_flush_raw[s]  = (w_new_iss  && (FW'(s) < w_fstage)) ||
                                 (w_pend_iss && (FW'(s) < r_pend_stage));
    end

    assign w_keep_stall = w_live && w_valid && !w_any_iss;
    assign w_any_stall  = w_keep_stall;

    assign stall      = w_keep_stall ? w_stall_raw  : '0;
    assign bubble     = w_keep_stall ? w_bubble_raw : '0;
    assign flush      = w_live       ? w_flush_raw  : '0;
    assign halt_code  = w_keep_stall ? (w_depth + SW'(1)) : '0;
    assign flush_pend = (r_state == ST_PEND);
    assign stall_cnt  = r_cnt;
    assign hang       = r_hang;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN, ST_STALL: begin
                if (w_pend_nxt)       w_state_nxt = ST_PEND;
                else if (w_any_stall) w_state_nxt = ST_STALL;
                else                  w_state_nxt = ST_RUN;
            end
            ST_PEND: begin
                if (w_pend_nxt)       w_state_nxt = ST_PEND;
                else if (w_any_stall) w_state_nxt = ST_STALL;
                else                  w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            r_pend_stage <= '0;
            r_cnt        <= '0;
            r_wd         <= '0;
            r_hang       <= 1'b0;
        end else begin
            r_pend_stage <= w_pend_nxt ? w_ps_nxt : '0;

            if (cnt_clr) begin
                r_cnt <= '0;
            end else if (w_any_stall && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (!w_any_stall) begin
                r_wd <= '0;
            end else if (r_wd != C_TO) begin
                r_wd <= r_wd + WD_W'(1);
            end

            if (w_any_stall && (r_wd == (C_TO - WD_W'(1)))) begin
                r_hang <= 1'b1;
            end
        end
    end

endmodule : pipe_stall_ctrl
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : tb_pipe_stall_ctrl                                          |
// | Brief   : Directed + random bench for pipe_stall_ctrl against a       |
// |           rule-level reference model.                                 |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_pipe_stall_ctrl;

    localparam int STAGES = 5;
    localparam int NREQ   = 4;
    localparam int SW     = 3;
    localparam int CNT_W  = 3;
    localparam int TO     = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   stall_req;
    logic              flush_req;
    logic [SW-1:0]     flush_stage;
    logic              cnt_clr;
    logic [STAGES-1:0] stall;
    logic [STAGES-1:0] bubble;
    logic [STAGES-1:0] flush;
    logic [SW-1:0]     halt_code;
    logic              flush_pend;
    logic [CNT_W-1:0]  stall_cnt;
    logic              hang;

    pipe_stall_ctrl #(
        .STAGES    (STAGES),
        .NREQ      (NREQ),
        .SW        (SW),
        .REQ_STAGE ({3'd3, 3'd0, 3'd3, 3'd0}),
        .CNT_W     (CNT_W),
        .TO_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_req   (stall_req),
        .flush_req   (flush_req),
        .flush_stage (flush_stage),
        .cnt_clr     (cnt_clr),
        .stall       (stall),
        .bubble      (bubble),
        .flush       (flush),
        .halt_code   (halt_code),
        .flush_pend  (flush_pend),
        .stall_cnt   (stall_cnt),
        .hang        (hang)
    );

    always #5 clk = ~clk;

    // Stage frozen by each requester, index = requester number.
    int req_stage_tab [NREQ] = '{0, 3, 0, 3};

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    bit m_pend;
    int m_ps;
    int m_cnt;
    int m_wd;
    bit m_hang;

    // Expected combinational values for the current cycle
    int e_stall, e_bubble, e_flush, e_halt;
    bit e_pend_nxt;
    int e_ps_nxt;

    function automatic int low_mask(input int n);
        return (1 << n) - 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_eval();
        int d, f;
        bit hs, nb, ni, pi, pb;
        d = -1;
        for (int i = 0; i < NREQ; i++)
            if (stall_req[i] && req_stage_tab[i] > d) d = req_stage_tab[i];
        hs = (d >= 0);
        f  = (int'(flush_stage) > STAGES) ? STAGES : int'(flush_stage);
        nb = flush_req && hs && (d >= f);
        ni = flush_req && !nb;
        pi = m_pend && !(hs && d >= m_ps);
        pb = m_pend && !pi;
        e_flush = (ni ? low_mask(f) : 0) | (pi ? low_mask(m_ps) : 0);
        if (ni || pi || !hs) begin
            e_stall = 0; e_bubble = 0; e_halt = 0;
        end else begin
            e_stall  = low_mask(d + 1);
            e_bubble = (d + 1 < STAGES) ? (1 << (d + 1)) : 0;
            e_halt   = d + 1;
        end
        e_pend_nxt = (nb || pb) && !(ni || pi);
        e_ps_nxt   = 0;
        if (pb && m_ps > e_ps_nxt) e_ps_nxt = m_ps;
        if (nb && f > e_ps_nxt)    e_ps_nxt = f;
        if (!rst) begin
            e_stall = 0; e_bubble = 0; e_flush = 0; e_halt = 0;
        end
    endtask

    task automatic model_step();
        if (!rst) begin
            m_pend = 0; m_ps = 0; m_cnt = 0; m_wd = 0; m_hang = 0;
        end else begin
            if (cnt_clr) m_cnt = 0;
            else if (e_stall != 0 && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            m_wd = (e_stall != 0) ? m_wd + 1 : 0;
            if (m_wd >= TO) m_hang = 1;
            m_pend = e_pend_nxt;
            m_ps   = e_pend_nxt ? e_ps_nxt : 0;
        end
    endtask

    task automatic settle();
        #3;
        model_eval();
        chk("stall",      32'(stall),      32'(e_stall));
        chk("bubble",     32'(bubble),     32'(e_bubble));
        chk("flush",      32'(flush),      32'(e_flush));
        chk("halt_code",  32'(halt_code),  32'(e_halt));
        chk("flush_pend", 32'(flush_pend), rst ? 32'(m_pend) : 32'd0);
        chk("stall_cnt",  32'(stall_cnt),  rst ? 32'(m_cnt)  : 32'd0);
        chk("hang",       32'(hang),       rst ? 32'(m_hang) : 32'd0);
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    initial begin
        rst = 1'b0; stall_req = '0; flush_req = 1'b0; flush_stage = '0; cnt_clr = 1'b0;
        m_pend = 0; m_ps = 0; m_cnt = 0; m_wd = 0; m_hang = 0;
        @(posedge clk); #1;
        settle();
        chk("rst_stall", 32'(stall), 32'd0);
        advance();
        cycle();
        rst = 1'b1;

        // Basic stall decode
        stall_req = 4'b0010;
        settle();
        chk("mem_stall",  32'(stall),     32'b01111);
        chk("mem_bubble", 32'(bubble),    32'b10000);
        chk("mem_halt",   32'(halt_code), 32'd4);
        advance();
        stall_req = 4'b0001;
        settle();
        chk("if_stall",  32'(stall),  32'b00001);
        chk("if_bubble", 32'(bubble), 32'b00010);
        advance();
        stall_req = 4'b0000;
        cycle();

        // Unblocked flush
        flush_req = 1'b1; flush_stage = 3'd2;
        settle();
        chk("flush_now", 32'(flush), 32'b00011);
        advance();
        flush_req = 1'b0;
        settle();
        chk("no_pend", 32'(flush_pend), 32'd0);
        advance();

        // Blocked flush deferred until stall drops
        stall_req = 4'b0010; flush_req = 1'b1; flush_stage = 3'd2;
        cycle();
        flush_req = 1'b0;
        settle();
        chk("pend_set", 32'(flush_pend), 32'd1);
        advance();
        cycle();
        stall_req = 4'b0000;
        settle();
        chk("pend_issue", 32'(flush), 32'b00011);
        advance();
        settle();
        chk("pend_clr", 32'(flush_pend), 32'd0);
        advance();

        // Two blocked flushes merge into the deeper one
        stall_req = 4'b0010; flush_req = 1'b1; flush_stage = 3'd1;
        cycle();
        flush_stage = 3'd2;
        cycle();
        flush_req = 1'b0;
        cycle();
        stall_req = 4'b0000;
        settle();
        chk("merge_issue", 32'(flush), 32'b00011);
        advance();
        cycle();

        // Asynchronous reset in the middle of a stall
        stall_req = 4'b0010;
        settle();
        rst = 1'b0;
        settle();
        chk("rst_mid_stall", 32'(stall),     32'd0);
        chk("rst_mid_halt",  32'(halt_code), 32'd0);
        advance();
        rst = 1'b1;
        settle();
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
        advance();
        stall_req = 4'b0000;
        cycle();

        // Watchdog and counter saturation
        stall_req = 4'b0001;
        for (int i = 0; i < TO; i++) begin
            settle();
            chk("hang_pre", 32'(hang), 32'd0);
            advance();
        end
        settle();
        chk("hang_set", 32'(hang),      32'd1);
        chk("cnt_sat",  32'(stall_cnt), 32'd7);
        advance();
        stall_req = 4'b0000;
        cycle();
        settle();
        chk("hang_sticky", 32'(hang), 32'd1);
        advance();

        // Clear beats increment
        stall_req = 4'b0001; cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0; stall_req = 4'b0000;
        settle();
        chk("cnt_clr", 32'(stall_cnt), 32'd0);
        advance();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            stall_req   = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            flush_req   = ($urandom_range(0, 2) == 0);
            flush_stage = 3'($urandom_range(0, 7));
            cnt_clr     = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_pipe_stall_ctrl
`default_nettype wire
